// File: rtl/serial_sample_rx_if.sv
// Valid/ready word port carrying received samples toward the FT245 TX side.
interface serial_sample_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;

  modport master (output data_o, output valid_o, input ready_i);
  modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/serial_sample_rx.sv
// Deserializes nsync-framed, MSB-first words clocked by bclk into parallel
// samples on a registered valid/ready port, with sticky overflow/framing flags.
module serial_sample_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clr_i,
  input  logic              sin,
  input  logic              bclk_in,
  input  logic              nsync_in,
  serial_sample_rx_if.master tx,
  output logic              overflow_o,
  output logic              frame_err_o,
  output logic [15:0]       word_count_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [SYNC_STAGES-1:0] sin_sync_r;
  logic [SYNC_STAGES-1:0] bclk_sync_r;
  logic [SYNC_STAGES-1:0] nsync_sync_r;
  logic [SYNC_STAGES-1:0] flush_r;
  logic                   bclk_prev_r;
  logic                   nsync_prev_r;
  logic                   armed_r;

  logic                   sin_s;
  logic                   bclk_s;
  logic                   nsync_s;
  logic                   bclk_rise_s;
  logic                   nsync_fall_s;
  logic                   nsync_rise_s;

  logic [1:0]             state_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [DATA_WIDTH-1:0]  shift_r;
  logic                   word_done_r;

  logic [DATA_WIDTH-1:0]  data_r;
  logic                   valid_r;
  logic                   overflow_r;
  logic                   frame_err_r;
  logic [15:0]            word_count_r;

  logic                   consume_s;
  logic                   load_s;
  logic                   overflow_evt_s;
  logic                   frame_err_evt_s;

  assign sin_s        = sin_sync_r[SYNC_STAGES-1];
  assign bclk_s       = bclk_sync_r[SYNC_STAGES-1];
  assign nsync_s      = nsync_sync_r[SYNC_STAGES-1];
  assign bclk_rise_s  = bclk_s & ~bclk_prev_r;
  assign nsync_fall_s = ~nsync_s & nsync_prev_r;
  assign nsync_rise_s = nsync_s & ~nsync_prev_r;

  // Synchronizers, edge-detect flops, and a post-reset arm that ignores a frame already in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      sin_sync_r   <= {SYNC_STAGES{1'b0}};
      bclk_sync_r  <= {SYNC_STAGES{1'b0}};
      nsync_sync_r <= {SYNC_STAGES{1'b1}};
      flush_r      <= {SYNC_STAGES{1'b0}};
      bclk_prev_r  <= 1'b0;
      nsync_prev_r <= 1'b1;
      armed_r      <= 1'b0;
    end else begin
      sin_sync_r   <= {sin_sync_r[SYNC_STAGES-2:0], sin};
      bclk_sync_r  <= {bclk_sync_r[SYNC_STAGES-2:0], bclk_in};
      nsync_sync_r <= {nsync_sync_r[SYNC_STAGES-2:0], nsync_in};
      flush_r      <= {flush_r[SYNC_STAGES-2:0], 1'b1};
      bclk_prev_r  <= bclk_s;
      nsync_prev_r <= nsync_s;
      armed_r      <= armed_r | (flush_r[SYNC_STAGES-1] & nsync_s);
    end
  end

  // Frame state machine and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= {CNT_W{1'b0}};
      shift_r     <= {DATA_WIDTH{1'b0}};
      word_done_r <= 1'b0;
    end else begin
      word_done_r <= 1'b0;
      if (!enable) begin
        state_r   <= ST_IDLE;
        bit_cnt_r <= {CNT_W{1'b0}};
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (nsync_fall_s && armed_r) begin
              shift_r   <= {DATA_WIDTH{1'b0}};
              bit_cnt_r <= {CNT_W{1'b0}};
              state_r   <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            // nsync_rise takes precedence over a coincident bclk edge
            if (nsync_rise_s) begin
              state_r <= ST_IDLE;
            end else if (bclk_rise_s) begin
              shift_r   <= {shift_r[DATA_WIDTH-2:0], sin_s};
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              if (bit_cnt_r == CNT_W'(DATA_WIDTH - 1)) begin
                word_done_r <= 1'b1;
                state_r     <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (nsync_rise_s) begin
              state_r <= ST_IDLE;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign consume_s       = valid_r & tx.ready_i;
  assign load_s          = word_done_r & (~valid_r | tx.ready_i);
  assign overflow_evt_s  = word_done_r & valid_r & ~tx.ready_i;
  assign frame_err_evt_s = enable & (state_r == ST_SHIFT) & nsync_rise_s;

  // Output register, word counter and sticky flags (set wins over clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r       <= {DATA_WIDTH{1'b0}};
      valid_r      <= 1'b0;
      word_count_r <= 16'd0;
      overflow_r   <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      if (load_s) begin
        data_r       <= shift_r;
        valid_r      <= 1'b1;
        word_count_r <= word_count_r + 16'd1;
      end else if (consume_s) begin
        valid_r <= 1'b0;
      end

      if (overflow_evt_s) begin
        overflow_r <= 1'b1;
      end else if (clr_i) begin
        overflow_r <= 1'b0;
      end

      if (frame_err_evt_s) begin
        frame_err_r <= 1'b1;
      end else if (clr_i) begin
        frame_err_r <= 1'b0;
      end
    end
  end

  assign tx.data_o    = data_r;
  assign tx.valid_o   = valid_r;
  assign overflow_o   = overflow_r;
  assign frame_err_o  = frame_err_r;
  assign word_count_o = word_count_r;

endmodule

// File: tb/tb_serial_sample_rx.sv
// Self-checking bench for serial_sample_rx: directed corner sequences, a
// vector table of frames, and randomized frames checked against a word queue.
module tb_serial_sample_rx;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        clr_i;
  logic        sin;
  logic        bclk_in;
  logic        nsync_in;
  logic        overflow_o;
  logic        frame_err_o;
  logic [15:0] word_count_o;

  serial_sample_rx_if #(.DATA_WIDTH(8)) tx_if ();

  serial_sample_rx #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .clr_i        (clr_i),
    .sin          (sin),
    .bclk_in      (bclk_in),
    .nsync_in     (nsync_in),
    .tx           (tx_if),
    .overflow_o   (overflow_o),
    .frame_err_o  (frame_err_o),
    .word_count_o (word_count_o)
  );

  typedef struct {
    logic [7:0] word;
    int         nbits;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t       vecs [6];
  int         tests;
  int         fails;
  int         exp_cnt;
  logic       mon_on;
  logic       rand_ready;
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got %0d tests, required completion", tests);
    $fatal(1, "bench did not complete");
  end

  // Records every handshake that will complete on the coming rising edge
  always @(negedge clk) begin
    #1;
    if (mon_on && tx_if.valid_o && tx_if.ready_i) got_q.push_back(tx_if.data_o);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rand_ready) tx_if.ready_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic pulse_ready();
    tx_if.ready_i = 1'b1;
    tick(1);
    tx_if.ready_i = 1'b0;
    tick(1);
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    tick(1);
    clr_i = 1'b0;
    tick(1);
  endtask

  // mode: 0 plain, 1 latency check, 2 align consume with completion,
  //       3 reset during bit 4, 4 enable low during bit 4
  task automatic send_frame(input logic [7:0] w, input int nbits, input int half, input int mode);
    nsync_in = 1'b0;
    tick(half);
    for (int i = 0; i < nbits; i++) begin
      sin = w[7-i];
      tick(half);
      bclk_in = 1'b1;
      for (int c = 1; c <= half; c++) begin
        tick(1);
        if (i == nbits - 1 && mode == 1 && c == 3) check("latency_before", tx_if.valid_o, 32'd0);
        if (i == nbits - 1 && mode == 1 && c == 4) check("latency_at", tx_if.valid_o, 32'd1);
        if (i == nbits - 1 && mode == 2 && c == 3) begin
          check("simul_valid_before", tx_if.valid_o, 32'd1);
          tx_if.ready_i = 1'b1;
        end
        if (i == nbits - 1 && mode == 2 && c == 4) begin
          tx_if.ready_i = 1'b0;
          check("simul_valid_after", tx_if.valid_o, 32'd1);
          check("simul_data", tx_if.data_o, 32'(w));
        end
        if (i == 3 && mode == 3 && c == 1) begin
          rst = 1'b1;
          tick(1);
          check("abort_rst_data", tx_if.data_o, 32'd0);
          check("abort_rst_valid", tx_if.valid_o, 32'd0);
          check("abort_rst_count", word_count_o, 32'd0);
          check("abort_rst_ovf", overflow_o, 32'd0);
          check("abort_rst_err", frame_err_o, 32'd0);
          rst = 1'b0;
        end
        if (i == 3 && mode == 4 && c == 1) begin
          enable = 1'b0;
          tick(1);
          enable = 1'b1;
        end
      end
      bclk_in = 1'b0;
    end
    tick(half);
    nsync_in = 1'b1;
    tick(half + 4);
  endtask

  initial begin
    logic [7:0] w;
    int         h;

    vecs[0] = '{8'hA5, 8, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 5, 1'b0, 8'hA5, 1'b1};
    vecs[2] = '{8'h5A, 8, 1'b1, 8'h5A, 1'b0};
    vecs[3] = '{8'h00, 8, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 3, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h81, 8, 1'b1, 8'h81, 1'b0};

    tests = 0;
    fails = 0;
    exp_cnt = 0;
    mon_on = 1'b0;
    rand_ready = 1'b0;
    rst = 1'b1;
    enable = 1'b1;
    clr_i = 1'b0;
    sin = 1'b0;
    bclk_in = 1'b0;
    nsync_in = 1'b1;
    tx_if.ready_i = 1'b0;

    tick(4);
    check("reset_data", tx_if.data_o, 32'd0);
    check("reset_valid", tx_if.valid_o, 32'd0);
    check("reset_ovf", overflow_o, 32'd0);
    check("reset_err", frame_err_o, 32'd0);
    check("reset_count", word_count_o, 32'd0);
    rst = 1'b0;
    tick(6);

    // Basic frame with exact latency
    send_frame(8'hA5, 8, 8, 1);
    exp_cnt = 1;
    check("basic_data", tx_if.data_o, 32'hA5);
    check("basic_count", word_count_o, 32'(exp_cnt));
    check("basic_ovf", overflow_o, 32'd0);
    check("basic_err", frame_err_o, 32'd0);
    pulse_ready();
    check("basic_consumed", tx_if.valid_o, 32'd0);

    // Back-to-back with ready held high
    got_q.delete();
    mon_on = 1'b1;
    tx_if.ready_i = 1'b1;
    send_frame(8'h00, 8, 8, 0);
    send_frame(8'hFF, 8, 8, 0);
    send_frame(8'h3C, 8, 8, 0);
    tick(6);
    mon_on = 1'b0;
    tx_if.ready_i = 1'b0;
    exp_cnt = 4;
    check("b2b_handshakes", got_q.size(), 32'd3);
    if (got_q.size() == 3) begin
      check("b2b_word0", got_q[0], 32'h00);
      check("b2b_word1", got_q[1], 32'hFF);
      check("b2b_word2", got_q[2], 32'h3C);
    end
    check("b2b_count", word_count_o, 32'(exp_cnt));

    // Overflow
    send_frame(8'h11, 8, 8, 0);
    send_frame(8'h22, 8, 8, 0);
    exp_cnt = 5;
    check("ovf_data", tx_if.data_o, 32'h11);
    check("ovf_flag", overflow_o, 32'd1);
    check("ovf_count", word_count_o, 32'(exp_cnt));
    pulse_ready();
    check("ovf_consumed", tx_if.valid_o, 32'd0);
    pulse_clr();
    check("ovf_cleared", overflow_o, 32'd0);

    // Completion aligned with consumption
    send_frame(8'h66, 8, 8, 0);
    send_frame(8'h99, 8, 8, 2);
    exp_cnt = 7;
    check("simul_ovf", overflow_o, 32'd0);
    check("simul_count", word_count_o, 32'(exp_cnt));
    pulse_ready();

    // Reset mid-frame
    send_frame(8'h42, 8, 8, 0);
    send_frame(8'h7E, 8, 8, 3);
    exp_cnt = 0;
    check("post_rst_valid", tx_if.valid_o, 32'd0);
    check("post_rst_err", frame_err_o, 32'd0);
    send_frame(8'hC3, 8, 8, 0);
    exp_cnt = 1;
    check("post_rst_data", tx_if.data_o, 32'hC3);
    check("post_rst_count", word_count_o, 32'(exp_cnt));
    pulse_ready();

    // Enable dropped mid-frame
    send_frame(8'hE7, 8, 8, 4);
    check("en_abort_valid", tx_if.valid_o, 32'd0);
    check("en_abort_err", frame_err_o, 32'd0);
    check("en_abort_ovf", overflow_o, 32'd0);
    check("en_abort_count", word_count_o, 32'(exp_cnt));
    send_frame(8'h18, 8, 8, 0);
    exp_cnt = 2;
    check("en_next_data", tx_if.data_o, 32'h18);
    check("en_next_count", word_count_o, 32'(exp_cnt));
    pulse_ready();

    // Vector table, including short frames
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].word, vecs[v].nbits, 8, 0);
      tick(4);
      if (vecs[v].exp_valid) exp_cnt++;
      check($sformatf("vec%0d_valid", v), tx_if.valid_o, 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d_data", v), tx_if.data_o, 32'(vecs[v].exp_data));
      check($sformatf("vec%0d_err", v), frame_err_o, 32'(vecs[v].exp_err));
      check($sformatf("vec%0d_count", v), word_count_o, 32'(exp_cnt));
      pulse_ready();
      pulse_clr();
    end

    // Randomized frames, rates and ready pattern against the word queue
    got_q.delete();
    exp_q.delete();
    mon_on = 1'b1;
    rand_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      w = 8'($urandom);
      h = int'($urandom_range(3, 6));
      send_frame(w, 8, h, 0);
      exp_q.push_back(w);
      exp_cnt++;
    end
    rand_ready = 1'b0;
    tx_if.ready_i = 1'b1;
    tick(10);
    mon_on = 1'b0;
    tx_if.ready_i = 1'b0;
    check("rand_words", got_q.size(), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("rand_word%0d", k), got_q[k], 32'(exp_q[k]));
    check("rand_ovf", overflow_o, 32'd0);
    check("rand_err", frame_err_o, 32'd0);
    check("rand_count", word_count_o, 32'(exp_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_sample_rx.md
# serial_sample_rx

Receive-side counterpart of the modulator's serial sample output (`sin` data, `bclk`, `nsync`). It deserializes framed words back into parallel samples and presents them on a valid/ready port that matches the FT245 wrapper's TX simple interface (`tx_data_si`, `tx_valid_si`, `tx_ready_si`). This closes a loopback path: host → FIFO → modulator → `serial_sample_rx` → host, used for link verification and bench capture.

## Interface
- `DATA_WIDTH`, default 8: bits per word; also the width of `data_o`.
- `SYNC_STAGES`, default 2: number of synchronizer flops on each asynchronous input (minimum 2).
- `clk`  input  1: system clock (256 MHz PLL output).
- `rst`  input  1: reset, synchronous, active-high; clock `clk`.
- `enable`  input  1: receiver enable. When low, the receiver is held in IDLE.
- `clr_i`  input  1: one-cycle pulse that clears the sticky flags `overflow_o` and `frame_err_o`.
- `sin`  input  1: serial data line. Asynchronous to `clk`.
- `bclk_in`  input  1: bit clock. Asynchronous to `clk`.
- `nsync_in`  input  1: frame strobe, active-low. Asynchronous to `clk`.
- `data_o`  output  DATA_WIDTH: received word; connects to `tx_data_si`.
- `valid_o`  output  1: `data_o` holds an unconsumed word; connects to `tx_valid_si`.
- `ready_i`  input  1: downstream accepts the word; connects to `tx_ready_si`.
- `overflow_o`  output  1: sticky; a completed word was dropped because the output register was still full.
- `frame_err_o`  output  1: sticky; `nsync` rose before a full word had been received.
- `word_count_o`  output  16: count of words loaded into the output register.

## Operation
- **Input synchronization.** `sin`, `bclk_in` and `nsync_in` each pass through their own `SYNC_STAGES` flop chain, so all three see the same delay. Synchronizer reset values: `nsync`=1, `bclk`=0, `sin`=0.
- **Edge detection.** One extra flop on the synchronized `bclk` and on the synchronized `nsync` provides edge detection:
  - `bclk_rise` = synchronized `bclk` is 1 now and was 0 the cycle before.
  - `nsync_fall` and `nsync_rise` are derived the same way.
- **Protocol.** A frame starts on the falling edge of `nsync`. Data is sampled on each rising edge of `bclk` while `nsync` is low. Bits arrive MSB first, and a frame carries exactly `DATA_WIDTH` bits.
- **State machine** (bit counter width is clog2(DATA_WIDTH+1)):
  - IDLE: on `nsync_fall` with `enable`=1, clear the shift register and bit counter and go to SHIFT.
  - SHIFT, on `bclk_rise`: shift in the synchronized `sin` (left shift, new bit at the LSB) and increment the counter. When the counter reaches `DATA_WIDTH`, raise the internal flag `word_done` and go to WAIT_END.
  - SHIFT, on `nsync_rise` before the count is complete: set `frame_err_o`, discard the partial word, and go to IDLE.
  - If `bclk_rise` and `nsync_rise` occur in the same cycle in SHIFT, `nsync_rise` wins: the bit is not shifted.
  - WAIT_END: ignore any further `bclk` edges. On `nsync_rise`, go to IDLE.
  - `enable` low in any state: go to IDLE on the next cycle and discard any partial word. No flags are set.
- **Output register.** Consumption happens when `valid_o`=1 and `ready_i`=1.
  - `word_done` with `valid_o`=0: load `data_o`, set `valid_o`, increment `word_count_o`.
  - `word_done` with `valid_o`=1 and `ready_i`=1 in the same cycle: load the new word, keep `valid_o`=1, increment `word_count_o`. No overflow.
  - `word_done` with `valid_o`=1 and `ready_i`=0: keep the old word, set `overflow_o`, do not increment `word_count_o`.
  - Consumption without `word_done`: clear `valid_o`. `data_o` holds its last value.
- **Flag and counter rules.**
  - `word_count_o` wraps from 0xFFFF to 0x0000.
  - If `clr_i` and a new error event occur in the same cycle, the flag stays set (set has priority).
- **Reset.** `rst` has priority over everything, including a frame in progress.
  - Reset values: `data_o`=0, `valid_o`=0, `overflow_o`=0, `frame_err_o`=0, `word_count_o`=0, state IDLE, counter 0.
  - A frame in progress when reset is released is not resynchronized. The receiver waits for the next `nsync_fall`.

## Timing
- A pin edge becomes visible to the state machine `SYNC_STAGES`+1 cycles later: 3 cycles with defaults.
- Latency from the last `bclk` rising edge at the pin to `valid_o`=1 is `SYNC_STAGES`+2 cycles: 4 cycles with defaults.
- `bclk` high time and low time must each be at least `SYNC_STAGES`+1 `clk` cycles.
- `sin` must be stable from `SYNC_STAGES` cycles before each `bclk` rising edge until `SYNC_STAGES` cycles after it.
- `nsync` must be high for at least `SYNC_STAGES`+1 cycles between frames.
- `valid_o` and `data_o` are registered. `ready_i` is sampled combinationally into next-state logic only; there is no combinational path from `ready_i` to any output.
- Sustained throughput is one word per frame. With `ready_i` held at 1, no word is lost at any legal `bclk` rate.

## Test plan
- **Basic frame, MSB first.** Reset, `enable`=1, `ready_i`=0. Send 0xA5 MSB first with `bclk` period 16 cycles → `valid_o`=1 exactly 4 cycles after the 8th `bclk` rising edge, `data_o`=0xA5, `word_count_o`=1, no flags set.
- **Back-to-back frames.** Send 0x00, 0xFF, 0x3C with `ready_i`=1 → three one-word handshakes with exactly those values in order, `word_count_o`=3.
- **Overflow.** Send 0x11 then 0x22 with `ready_i`=0 → `data_o` stays 0x11, `overflow_o`=1, `word_count_o`=1. Then pulse `ready_i` → `valid_o`=0. Then pulse `clr_i` → `overflow_o`=0.
- **Short frame.** Raise `nsync` after 5 bits → `frame_err_o`=1, `valid_o` stays 0. The following full frame 0x5A is delivered correctly.
- **Simultaneous consume and completion.** Hold `ready_i`=1 and align a new `word_done` with the consume cycle → new word loaded, `valid_o` continuously 1, `overflow_o`=0.
- **Abort mid-frame.** Assert `rst` during bit 4 → all outputs return to their reset values on the next edge. The next complete frame is received correctly. Repeat the same case with `enable` dropped for 1 cycle instead of `rst` → partial word discarded, no flags set.
